exe_unit_mc: RTL and testbench

Parametrised multi-cycle execute unit that replaces the fixed single-cycle EX stage. It accepts one decoded operation per valid/ready handshake and computes the full RV integer ALU set, W-variants, branch/jump resolution and an iterative MUL. It holds each result in an output register until the downstream handshake consumes it. It sits between ID and MEM/WB and is stalled only through the handshakes.

---
 rtl/exe_unit_mc.sv | 243 ++++++++++++++++++++++++
 tb/tb_exe_unit_mc.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_unit_mc.sv
// Multi-cycle execute unit: single-cycle RV integer ALU, branch/jump resolution
// and an iterative multiplier, with a valid/ready result register.
module exe_unit_mc #(
    parameter int XLEN     = 64,
    parameter int MUL_BITS = 1,
    parameter int W_OPS_EN = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      opcode_i,
    input  logic [2:0]      funct3_i,
    input  logic [6:0]      funct7_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [XLEN-1:0] t1_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            rd_wen,
    output logic [XLEN-1:0] rd_data,
    output logic            pc_jmp,
    output logic [XLEN-1:0] pc_jmpaddr,
    output logic            illegal,
    output logic            busy
);

    localparam int N   = XLEN / MUL_BITS;
    localparam int CW  = (N > 1) ? $clog2(N) : 1;
    localparam int SHW = $clog2(XLEN);
    localparam bit W_EN = (XLEN == 64) && (W_OPS_EN != 0);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [4:0] OPC_OP_IMM    = 5'b00100;
    localparam logic [4:0] OPC_OP        = 5'b01100;
    localparam logic [4:0] OPC_LUI       = 5'b01101;
    localparam logic [4:0] OPC_AUIPC     = 5'b00101;
    localparam logic [4:0] OPC_JAL       = 5'b11011;
    localparam logic [4:0] OPC_JALR      = 5'b11001;
    localparam logic [4:0] OPC_BRANCH    = 5'b11000;
    localparam logic [4:0] OPC_OP_IMM_32 = 5'b00110;
    localparam logic [4:0] OPC_OP_32     = 5'b01110;
    localparam logic [6:0] F7_MULDIV     = 7'b0000001;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_out_valid;
    logic              r_rd_wen;
    logic [XLEN-1:0]   r_rd_data;
    logic              r_pc_jmp;
    logic [XLEN-1:0]   r_pc_jmpaddr;
    logic              r_illegal;
    logic [XLEN-1:0]   r_mcand;
    logic [XLEN-1:0]   r_mplier;
    logic [XLEN-1:0]   r_acc;
    logic [CW-1:0]     r_cnt;

    logic              w_accept;
    logic              w_is_mul;
    logic              w_mul_done;
    logic              w_mul_step;
    logic [XLEN-1:0]   w_acc_next;
    logic              w_res_wen;
    logic [XLEN-1:0]   w_res_data;
    logic              w_res_jmp;
    logic [XLEN-1:0]   w_res_addr;
    logic              w_res_ill;
    logic [XLEN-1:0]   w_sum;
    logic              w_lt;
    logic              w_ltu;
    logic              w_sub;
    logic [SHW-1:0]    w_shamt;
    logic [31:0]       w_w32;

    assign in_ready = !rst && (r_state == S_IDLE) && (!r_out_valid || out_ready) && !flush_i;
    assign w_accept = in_valid && in_ready;

    // The final MUL step waits while an older result is still unconsumed.
    assign w_mul_done = (r_state == S_MUL) && (r_cnt == LAST) && (!r_out_valid || out_ready);
    assign w_mul_step = (r_state == S_MUL) && ((r_cnt != LAST) || w_mul_done);
    assign w_acc_next = r_acc + r_mcand * XLEN'(r_mplier[MUL_BITS-1:0]);

    always_comb begin
        w_res_wen  = 1'b0;
        w_res_data = '0;
        w_res_jmp  = 1'b0;
        w_res_addr = '0;
        w_res_ill  = 1'b0;
        w_is_mul   = 1'b0;
        w_w32      = '0;
        w_sum      = op1_i + op2_i;
        w_lt       = $signed(op1_i) < $signed(op2_i);
        w_ltu      = op1_i < op2_i;
        w_shamt    = op2_i[SHW-1:0];
        w_sub      = funct7_i[5] && (opcode_i == OPC_OP || opcode_i == OPC_OP_32);
        case (opcode_i)
            OPC_OP_IMM, OPC_OP: begin
                if (opcode_i == OPC_OP && funct7_i == F7_MULDIV) begin
                    if (funct3_i == 3'b000) w_is_mul  = 1'b1;
                    else                    w_res_ill = 1'b1;
                end else begin
                    w_res_wen = 1'b1;
                    case (funct3_i)
                        3'b000:  w_res_data = w_sub ? (op1_i - op2_i) : w_sum;
                        3'b001:  w_res_data = op1_i << w_shamt;
                        3'b010:  w_res_data = XLEN'(w_lt);
                        3'b011:  w_res_data = XLEN'(w_ltu);
                        3'b100:  w_res_data = op1_i ^ op2_i;
                        3'b101:  w_res_data = funct7_i[5] ? XLEN'($signed(op1_i) >>> w_shamt)
                                                          : (op1_i >> w_shamt);
                        3'b110:  w_res_data = op1_i | op2_i;
                        default: w_res_data = op1_i & op2_i;
                    endcase
                end
            end
            OPC_OP_IMM_32, OPC_OP_32: begin
                if (!W_EN || (opcode_i == OPC_OP_32 && funct7_i == F7_MULDIV)) begin
                    w_res_ill = 1'b1;
                end else begin
                    case (funct3_i)
                        3'b000:  w_w32 = w_sub ? (op1_i[31:0] - op2_i[31:0]) : (op1_i[31:0] + op2_i[31:0]);
                        3'b001:  w_w32 = op1_i[31:0] << op2_i[4:0];
                        3'b101:  w_w32 = funct7_i[5] ? 32'($signed(op1_i[31:0]) >>> op2_i[4:0])
                                                     : (op1_i[31:0] >> op2_i[4:0]);
                        default: w_res_ill = 1'b1;
                    endcase
                    w_res_wen  = !w_res_ill;
                    w_res_data = XLEN'($signed(w_w32));
                end
            end
            OPC_LUI: begin
                w_res_wen  = 1'b1;
                w_res_data = op2_i;
            end
            OPC_AUIPC: begin
                w_res_wen  = 1'b1;
                w_res_data = w_sum;
            end
            OPC_JAL: begin
                w_res_wen  = 1'b1;
                w_res_data = op1_i;
                w_res_jmp  = 1'b1;
                w_res_addr = op2_i;
            end
            OPC_JALR: begin
                w_res_wen  = 1'b1;
                w_res_data = t1_i;
                w_res_jmp  = 1'b1;
                w_res_addr = {w_sum[XLEN-1:1], 1'b0};
            end
            OPC_BRANCH: begin
                w_res_addr = t1_i;
                case (funct3_i)
                    3'b000:  w_res_jmp = (op1_i == op2_i);
                    3'b001:  w_res_jmp = (op1_i != op2_i);
                    3'b100:  w_res_jmp = w_lt;
                    3'b101:  w_res_jmp = !w_lt;
                    3'b110:  w_res_jmp = w_ltu;
                    3'b111:  w_res_jmp = !w_ltu;
                    default: w_res_ill = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        if (flush_i) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_accept && w_is_mul) w_state_next = S_MUL;
                S_MUL:   if (w_mul_done) w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_rd_wen     <= 1'b0;
            r_rd_data    <= '0;
            r_pc_jmp     <= 1'b0;
            r_pc_jmpaddr <= '0;
            r_illegal    <= 1'b0;
            r_mcand      <= '0;
            r_mplier     <= '0;
            r_acc        <= '0;
            r_cnt        <= '0;
        end else if (flush_i) begin
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept && !w_is_mul) begin
                r_out_valid  <= 1'b1;
                r_rd_wen     <= w_res_wen;
                r_rd_data    <= w_res_data;
                r_pc_jmp     <= w_res_jmp && !w_res_ill;
                r_pc_jmpaddr <= w_res_addr;
                r_illegal    <= w_res_ill;
            end else if (w_mul_done) begin
                r_out_valid  <= 1'b1;
                r_rd_wen     <= 1'b1;
                r_rd_data    <= w_acc_next;
                r_pc_jmp     <= 1'b0;
                r_pc_jmpaddr <= '0;
                r_illegal    <= 1'b0;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_accept && w_is_mul) begin
                r_mcand  <= op1_i;
                r_mplier <= op2_i;
                r_acc    <= '0;
                r_cnt    <= '0;
            end else if (w_mul_step) begin
                r_acc    <= w_acc_next;
                r_mcand  <= r_mcand << MUL_BITS;
                r_mplier <= r_mplier >> MUL_BITS;
                r_cnt    <= r_cnt + 1'b1;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign rd_wen     = r_rd_wen;
    assign rd_data    = r_rd_data;
    assign pc_jmp     = r_pc_jmp;
    assign pc_jmpaddr = r_pc_jmpaddr;
    assign illegal    = r_illegal;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_exe_unit_mc.sv
// Scoreboard bench for exe_unit_mc: directed ops, expected records queued at issue
// and compared by an independent monitor when results are consumed.
module tb_exe_unit_mc;
    localparam int XLEN = 64;

    localparam logic [4:0] OP_IMM = 5'b00100, OP = 5'b01100, LUI = 5'b01101, AUIPC = 5'b00101;
    localparam logic [4:0] JAL = 5'b11011, JALR = 5'b11001, BR = 5'b11000, OP32 = 5'b01110;

    logic clk = 1'b0, rst = 1'b1, flush_i = 1'b0, in_valid = 1'b0, in_valid4 = 1'b0, out_ready = 1'b1;
    logic [4:0] opcode_i = '0;
    logic [2:0] funct3_i = '0;
    logic [6:0] funct7_i = '0;
    logic [XLEN-1:0] op1_i = '0, op2_i = '0, t1_i = '0;
    logic in_ready, out_valid, rd_wen, pc_jmp, illegal, busy;
    logic [XLEN-1:0] rd_data, pc_jmpaddr;
    logic in_ready4, out_valid4, rd_wen4, pc_jmp4, illegal4, busy4;
    logic [XLEN-1:0] rd_data4, pc_jmpaddr4;

    exe_unit_mc #(.XLEN(XLEN), .MUL_BITS(1), .W_OPS_EN(1)) u_dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .in_valid(in_valid), .in_ready(in_ready),
        .opcode_i(opcode_i), .funct3_i(funct3_i), .funct7_i(funct7_i),
        .op1_i(op1_i), .op2_i(op2_i), .t1_i(t1_i),
        .out_valid(out_valid), .out_ready(out_ready), .rd_wen(rd_wen), .rd_data(rd_data),
        .pc_jmp(pc_jmp), .pc_jmpaddr(pc_jmpaddr), .illegal(illegal), .busy(busy));

    exe_unit_mc #(.XLEN(XLEN), .MUL_BITS(4), .W_OPS_EN(1)) u_dut4 (
        .clk(clk), .rst(rst), .flush_i(flush_i), .in_valid(in_valid4), .in_ready(in_ready4),
        .opcode_i(opcode_i), .funct3_i(funct3_i), .funct7_i(funct7_i),
        .op1_i(op1_i), .op2_i(op2_i), .t1_i(t1_i),
        .out_valid(out_valid4), .out_ready(out_ready), .rd_wen(rd_wen4), .rd_data(rd_data4),
        .pc_jmp(pc_jmp4), .pc_jmpaddr(pc_jmpaddr4), .illegal(illegal4), .busy(busy4));

    always #5 clk = ~clk;

    typedef struct {
        string           name;
        logic            wen;
        logic [XLEN-1:0] data;
        logic            jmp;
        logic [XLEN-1:0] addr;
        logic            ill;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_errors = 0;

    function automatic exp_t mk(string name, logic wen, logic [XLEN-1:0] data,
                                logic jmp, logic [XLEN-1:0] addr, logic ill);
        exp_t e;
        e.name = name; e.wen = wen; e.data = data; e.jmp = jmp; e.addr = addr; e.ill = ill;
        return e;
    endfunction

    task automatic chk(string name, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every consumed result is matched against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_result: wen=%b data=%h jmp=%b addr=%h ill=%b",
                             rd_wen, rd_data, pc_jmp, pc_jmpaddr, illegal);
                end else begin
                    e = sb.pop_front();
                    if (rd_wen !== e.wen || illegal !== e.ill || pc_jmp !== e.jmp ||
                        (e.wen && rd_data !== e.data) || (e.jmp && pc_jmpaddr !== e.addr)) begin
                        n_errors++;
                        $display("FAIL %s: got wen=%b data=%h jmp=%b addr=%h ill=%b expected wen=%b data=%h jmp=%b addr=%h ill=%b",
                                 e.name, rd_wen, rd_data, pc_jmp, pc_jmpaddr, illegal,
                                 e.wen, e.data, e.jmp, e.addr, e.ill);
                    end
                end
            end
        end
    end

    task automatic issue(logic [4:0] opc, logic [2:0] f3, logic [6:0] f7,
                         logic [XLEN-1:0] a, logic [XLEN-1:0] b, logic [XLEN-1:0] t,
                         bit push, exp_t e, output int waits);
        opcode_i = opc; funct3_i = f3; funct7_i = f7; op1_i = a; op2_i = b; t1_i = t;
        in_valid = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!in_ready && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (waits >= 200) begin
            n_checks++; n_errors++;
            $display("FAIL accept_timeout_%s: in_ready stuck at %b, required 1", e.name, in_ready);
        end else if (push) begin
            sb.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    localparam logic [XLEN-1:0] ALL1 = '1;

    initial begin
        int w;
        int edges;
        bit busy_bad;
        exp_t nil;
        nil = mk("none", 1'b0, '0, 1'b0, '0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        chk("in_ready_in_reset", in_ready, 0);
        chk("out_valid_in_reset", out_valid, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Give the result register non-zero content so the reset check has teeth.
        issue(JAL, 3'b000, 7'h00, 64'h2000, 64'h3000, 64'h0, 1, mk("jal", 1, 64'h2000, 1, 64'h3000, 0), w);
        chk("jal_latency", out_valid, 1);
        issue(OP, 3'b000, 7'b0000001, 64'h1234, 64'h55, 64'h0, 0, nil, w);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_rd_wen", rd_wen, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_pc_jmp", pc_jmp, 0);
        chk("rst_pc_jmpaddr", pc_jmpaddr, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_busy", busy, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", in_ready, 1);
        @(posedge clk); #1;
        issue(OP_IMM, 3'b000, 7'h00, 64'd5, -64'sd3, 64'h0, 1, mk("addi", 1, 64'd2, 0, 0, 0), w);
        chk("addi_latency", out_valid, 1);
        @(posedge clk); #1;

        // MUL latency: N+1 edges from the accept edge, busy held throughout.
        issue(OP, 3'b000, 7'b0000001, ALL1, 64'd3, 64'h0, 1, mk("mul1", 1, 64'hFFFF_FFFF_FFFF_FFFD, 0, 0, 0), w);
        edges = 1; busy_bad = 0;
        while (!out_valid && edges < 200) begin
            if (!busy) busy_bad = 1;
            @(posedge clk); #1;
            edges++;
        end
        chk("mul1_latency", edges, 65);
        chk("mul1_busy_throughout", busy_bad, 0);
        @(posedge clk); #1;

        opcode_i = OP; funct3_i = 3'b000; funct7_i = 7'b0000001; op1_i = ALL1; op2_i = 64'd3;
        in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        edges = 1;
        while (!out_valid4 && edges < 200) begin
            @(posedge clk); #1;
            edges++;
        end
        chk("mul4_latency", edges, 17);
        chk("mul4_data", rd_data4, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("mul4_wen", rd_wen4, 1);
        @(posedge clk); #1;

        // Back-to-back issue with a ready sink: no accept stalls.
        issue(OP, 3'b000, 7'h00, 64'd1, 64'd2, 0, 1, mk("add_a", 1, 64'd3, 0, 0, 0), w);
        chk("b2b_stall_a", w, 0);
        issue(OP, 3'b000, 7'h00, 64'd10, -64'sd4, 0, 1, mk("add_b", 1, 64'd6, 0, 0, 0), w);
        chk("b2b_stall_b", w, 0);
        issue(OP, 3'b000, 7'h00, ALL1, 64'd1, 0, 1, mk("add_wrap", 1, 64'd0, 0, 0, 0), w);
        chk("b2b_stall_c", w, 0);
        issue(OP, 3'b000, 7'b0100000, 64'd5, 64'd7, 0, 1, mk("sub", 1, -64'sd2, 0, 0, 0), w);
        chk("b2b_stall_d", w, 0);
        repeat (3) @(posedge clk);
        #1;

        // Blocked sink: the held result and the stalled upstream are both visible.
        out_ready = 1'b0;
        issue(OP, 3'b000, 7'h00, 64'd100, 64'd23, 0, 1, mk("add_held", 1, 64'd123, 0, 0, 0), w);
        opcode_i = OP; funct3_i = 3'b000; funct7_i = 7'h00; op1_i = 64'd40; op2_i = 64'd2;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("held_in_ready", in_ready, 0);
            chk("held_rd_data", rd_data, 64'd123);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        issue(OP, 3'b000, 7'h00, 64'd40, 64'd2, 0, 1, mk("add_after_hold", 1, 64'd42, 0, 0, 0), w);

        issue(BR, 3'b101, 7'h00, ALL1, 64'd1, 64'h1000, 1, mk("bge", 0, 0, 0, 0, 0), w);
        issue(BR, 3'b111, 7'h00, ALL1, 64'd1, 64'h1000, 1, mk("bgeu", 0, 0, 1, 64'h1000, 0), w);
        issue(BR, 3'b100, 7'h00, ALL1, 64'd1, 64'h1040, 1, mk("blt", 0, 0, 1, 64'h1040, 0), w);
        issue(BR, 3'b000, 7'h00, 64'd7, 64'd7, 64'h2000, 1, mk("beq", 0, 0, 1, 64'h2000, 0), w);
        issue(BR, 3'b001, 7'h00, 64'd7, 64'd7, 64'h2000, 1, mk("bne", 0, 0, 0, 0, 0), w);
        issue(BR, 3'b010, 7'h00, 64'd7, 64'd7, 64'h2000, 1, mk("br_bad", 0, 0, 0, 0, 1), w);

        issue(OP32, 3'b000, 7'h00, 64'h7FFF_FFFF, 64'd1, 0, 1, mk("addw", 1, 64'hFFFF_FFFF_8000_0000, 0, 0, 0), w);
        issue(OP_IMM, 3'b101, 7'b0100001, 64'h8000_0000_0000_0000, 64'd63, 0, 1, mk("srai63", 1, ALL1, 0, 0, 0), w);
        issue(OP_IMM, 3'b101, 7'b0000001, 64'h8000_0000_0000_0000, 64'd63, 0, 1, mk("srli63", 1, 64'd1, 0, 0, 0), w);
        issue(OP, 3'b001, 7'h00, 64'd3, 64'd4, 0, 1, mk("sll", 1, 64'd48, 0, 0, 0), w);
        issue(OP, 3'b011, 7'h00, 64'd1, ALL1, 0, 1, mk("sltu", 1, 64'd1, 0, 0, 0), w);
        issue(OP, 3'b010, 7'h00, 64'd1, ALL1, 0, 1, mk("slt", 1, 64'd0, 0, 0, 0), w);
        issue(LUI, 3'b000, 7'h00, 64'd9, 64'h1234_5000, 0, 1, mk("lui", 1, 64'h1234_5000, 0, 0, 0), w);
        issue(AUIPC, 3'b000, 7'h00, 64'h400, 64'h1000, 0, 1, mk("auipc", 1, 64'h1400, 0, 0, 0), w);
        issue(JALR, 3'b000, 7'h00, 64'h1001, 64'h10, 64'h88, 1, mk("jalr", 1, 64'h88, 1, 64'h1010, 0), w);

        // Flush lands on the MUL completion edge: nothing may come out.
        issue(OP, 3'b000, 7'b0000001, 64'd6, 64'd7, 0, 0, nil, w);
        repeat (63) @(posedge clk);
        #1 flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_busy", busy, 0);
        @(posedge clk); #1;
        chk("flush_out_valid_later", out_valid, 0);

        issue(OP, 3'b001, 7'b0000001, 64'd6, 64'd7, 0, 1, mk("mulh_illegal", 0, 0, 0, 0, 1), w);
        chk("mulh_latency", out_valid, 1);

        edges = 0;
        while (sb.size() != 0 && edges < 200) begin
            @(posedge clk);
            edges++;
        end
        #1;
        chk("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
